// File: rtl/nn_stream_loader.sv
// Host-side byte-serial frame transmitter for neural_network.
// Streams a banked frame with two changes strobes, then captures the result.
module nn_stream_loader #(
    parameter int DATA_W      = 8,
    parameter int N_INPUTS    = 4,
    parameter int N_NEURONS   = 4,
    parameter int ADDR_W      = 5,
    parameter int GAP_CYCLES  = 1,
    parameter int RESULT_WAIT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              changes_out_o,
    input  logic [DATA_W-1:0] net_result_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              busy_o
);

    localparam int FRAME_LEN = N_INPUTS + N_NEURONS * (N_INPUTS + 2);
    localparam int WCNT_W    = 8;

    localparam logic [ADDR_W:0]   FRAME_LEN_X = (ADDR_W + 1)'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST_X      = ADDR_W'(N_INPUTS - 1);
    localparam logic [ADDR_W-1:0] LAST_P      = ADDR_W'(FRAME_LEN - 1);
    localparam logic [WCNT_W-1:0] GAP_LAST    = WCNT_W'(GAP_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST   = WCNT_W'(RESULT_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_X,
        S_STROBE1,
        S_GAP,
        S_SEND_P,
        S_STROBE2,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                chg_q, chg_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   bank_q [FRAME_LEN];
    logic [DATA_W-1:0]   rd_byte;
    logic                wr_ok;

    // Bank writes only land while idle, so an active frame never sees a change.
    assign wr_ok = (state_q == S_IDLE) && wr_en_i
                   && ({1'b0, wr_addr_i} < FRAME_LEN_X);

    assign rd_byte = bank_q[cnt_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_ok) begin
            bank_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            data_q  <= '0;
            chg_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            chg_q   <= chg_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // State names the action taken on the next edge; outputs are registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        data_d  = '0;
        chg_d   = 1'b0;
        res_d   = res_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    state_d = S_SEND_X;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_SEND_X: begin
                data_d = rd_byte;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_X) begin
                    state_d = S_STROBE1;
                end
            end
            S_STROBE1: begin
                chg_d  = 1'b1;
                wcnt_d = '0;
                if (GAP_CYCLES == 0) begin
                    state_d = S_SEND_P;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (wcnt_q == GAP_LAST) begin
                    state_d = S_SEND_P;
                end
            end
            S_SEND_P: begin
                data_d = rd_byte;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_P) begin
                    state_d = S_STROBE2;
                    cnt_d   = '0;
                end
            end
            S_STROBE2: begin
                chg_d  = 1'b1;
                wcnt_d = '0;
                if (RESULT_WAIT == 0) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                res_d   = net_result_i;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out_o     = data_q;
    assign changes_out_o  = chg_q;
    assign result_o       = res_q;
    assign result_valid_o = valid_q;
    assign busy_o         = busy_q;

endmodule
